fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter AWIDTH, default 32, PC/address width.
REQ-002 Parameter DWIDTH, default 32, instruction width.
REQ-003 Parameter DEPTH, default 32, instruction ROM depth in words; legal PC range 0..DEPTH-1.
REQ-004 Parameter RESET_PC, default 1, first word address fetched after reset (word 0 holds the null instruction).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 pc  out  AWIDTH  word address driven to ROM.
REQ-008 en_fetch  out  1  ROM read enable.
REQ-009 instr_in  in  DWIDTH  ROM read data, combinational from pc.
REQ-010 out_valid  out  1  out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  in  1  decode accepts the held instruction this cycle.
REQ-012 out_instr  out  DWIDTH  fetched instruction.
REQ-013 out_pc  out  AWIDTH  address out_instr was fetched from.
REQ-014 redirect_valid  in  1  branch/jump redirect request, one-cycle pulse.
REQ-015 redirect_pc  in  AWIDTH  redirect target word address.
REQ-016 halted  out  1  fetch stopped on null instruction.
REQ-017 fault  out  1  sticky illegal-target flag.
REQ-018 fetch_cnt  out  16  count of captured instructions.

Function
REQ-019 States SHALL be IDLE, FETCH, HALT; IDLE SHALL last exactly one cycle after rst deasserts, then go to FETCH unconditionally.
REQ-020 en_fetch SHALL be combinational: 1 iff state==FETCH, rst==0, and (out_valid==0 or out_ready==1).
REQ-021 Accept edge (en_fetch==1, no redirect, instr_in!=0): out_instr<=instr_in, out_pc<=pc, out_valid<=1, pc<=pc+1, fetch_cnt+1; zero-bubble throughput of one instruction per cycle.
REQ-022 Edge with out_valid==1, out_ready==1 and no capture: out_valid<=0.
REQ-023 out_valid==1, out_ready==0: out_instr, out_pc, pc SHALL hold stable.
REQ-024 PC increment from DEPTH-1 SHALL wrap to 0.
REQ-025 Accept edge with instr_in==0: no capture, pc held, state<=HALT, halted<=1; held output still drains per REQ-022.
REQ-026 In HALT en_fetch==0; only a legal redirect leaves HALT (to FETCH, halted<=0).
REQ-027 redirect_valid with redirect_pc<DEPTH, any non-IDLE state, fault==0: pc<=redirect_pc, out_valid<=0 (flush), state<=FETCH, halted<=0.
REQ-028 redirect_valid with redirect_pc>=DEPTH: fault<=1, state<=HALT, out_valid<=0, pc held.
REQ-029 Redirect SHALL take priority over a simultaneous accept; the ROM word at old pc is dropped and fetch_cnt not incremented.
REQ-030 While fault==1, redirects SHALL be ignored and en_fetch==0.
REQ-031 redirect_valid in IDLE SHALL be ignored.
REQ-032 fetch_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-033 rst==1 at an edge: state<=IDLE, pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, halted<=0, fault<=0, fetch_cnt<=0; en_fetch==0 while rst==1.
REQ-034 rst mid-operation SHALL override redirect, capture and halt in the same edge.

Verification
REQ-035 Reset release, ROM words 1..4 nonzero, out_ready=1 -> out_pc 1,2,3,4 on consecutive cycles, fetch_cnt=4, first out_valid two cycles after rst low.
REQ-036 out_ready=0 for 3 cycles while out_pc=2 -> out_instr/out_pc/pc frozen, en_fetch=0; out_ready=1 -> out_pc 3 next cycle.
REQ-037 ROM word 5 = 0 -> halted=1, pc=5, out_pc 4 drains; redirect_pc=2 -> halted=0, next out_pc=2.
REQ-038 redirect_pc=10 coinciding with accept at pc=6 -> word 6 dropped, out_valid=0 one cycle, next out_pc=10, fetch_cnt unchanged by the dropped word.
REQ-039 redirect_pc=32 (DEPTH=32) -> fault=1, en_fetch=0; later redirect_pc=3 ignored; rst clears fault, pc=1.
REQ-040 Sequential fetch reaching pc=31 -> next pc=0 and the word at address 0 (null) halts fetch.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a combinational instruction ROM, holds one
// fetched word in an output register with valid/ready handshake, stops on the null
// instruction, and takes branch/jump redirects with an illegal-target fault flag.
module fetch_ctrl #(
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RESET_PC = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] pc,
  output logic              en_fetch,
  input  logic [DWIDTH-1:0] instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_instr,
  output logic [AWIDTH-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       fetch_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } state_e;

  // Depth compared one bit wider so DEPTH == 2**AWIDTH still works.
  localparam logic [AWIDTH:0]   DepthExt = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LastPc   = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] ResetPc  = AWIDTH'(RESET_PC);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic                out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]   out_instr_q, out_instr_d;
  logic [AWIDTH-1:0]   out_pc_q, out_pc_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic [15:0]         fetch_cnt_q, fetch_cnt_d;
  logic                en_fetch_w;
  logic                redirect_legal;
  logic [AWIDTH-1:0]   pc_inc;

  // ROM is read only when the output register is free or draining this cycle.
  always_comb begin
    en_fetch_w = (state_q == StFetch) && !rst && !fault_q && (!out_valid_q || out_ready);
  end

  // Target legality and sequential-increment with wrap at the top of the ROM.
  always_comb begin
    redirect_legal = ({1'b0, redirect_pc} < DepthExt);
    pc_inc         = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
  end

  // Next-state: redirect beats capture; a null word halts without capturing.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      default: begin
        if (redirect_valid && !fault_q) begin
          out_valid_d = 1'b0;
          if (redirect_legal) begin
            pc_d     = redirect_pc;
            state_d  = StFetch;
            halted_d = 1'b0;
          end else begin
            fault_d = 1'b1;
            state_d = StHalt;
          end
        end else begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
          if (en_fetch_w) begin
            if (instr_in != '0) begin
              out_instr_d = instr_in;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              pc_d        = pc_inc;
              if (fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_d = fetch_cnt_q + 16'd1;
              end
            end else begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign en_fetch  = en_fetch_w;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected out_pc sequence is queued by the stimulus,
// a negedge monitor pops and checks each handshake; state is spot-checked directly.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        en_fetch;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_cnt;

  logic [31:0] rom [32];
  logic [31:0] sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .en_fetch       (en_fetch),
    .instr_in       (instr_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr_in = (pc < 32'd32) ? rom[pc[4:0]] : 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0 : (32'hC0DE_0000 | a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] target, input int bound);
    int k;
    k = 0;
    while (pc !== target && k < bound) begin
      tick();
      k++;
    end
    chk("wait_pc", pc, target);
  endtask

  // Monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got out_pc %0h expected nothing", out_pc);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_out_pc", out_pc, e);
        chk("sb_out_instr", out_instr, word(e));
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 32; i++) rom[i] = word(i);
    rom[5] = 32'h0;
    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_en_fetch", {31'b0, en_fetch}, 0);
    chk("rst_pc", pc, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_fetch_cnt", {16'b0, fetch_cnt}, 0);
    chk("rst_fault", {31'b0, fault}, 0);

    // Startup: IDLE cycle, then first capture
    for (int i = 1; i <= 4; i++) sb_q.push_back(i);
    rst = 1'b0;
    tick();
    chk("idle_out_valid", {31'b0, out_valid}, 0);
    chk("first_en_fetch", {31'b0, en_fetch}, 1);
    chk("first_pc", pc, 1);
    tick();
    chk("first_valid", {31'b0, out_valid}, 1);
    chk("first_out_pc", out_pc, 1);
    tick();
    chk("second_out_pc", out_pc, 2);

    // Stall with out_pc=2
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_pc", out_pc, 2);
      chk("stall_instr", out_instr, word(2));
      chk("stall_pc", pc, 3);
      chk("stall_en_fetch", {31'b0, en_fetch}, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_en_fetch", {31'b0, en_fetch}, 1);
    tick();
    chk("unstall_out_pc", out_pc, 3);
    tick();
    chk("fourth_out_pc", out_pc, 4);

    // Null word at 5 halts; held word drains
    tick();
    chk("halt_halted", {31'b0, halted}, 1);
    chk("halt_pc", pc, 5);
    chk("halt_drained", {31'b0, out_valid}, 0);
    chk("halt_fetch_cnt", {16'b0, fetch_cnt}, 4);
    tick();
    chk("halt_en_fetch", {31'b0, en_fetch}, 0);
    chk("halt_hold", {31'b0, halted}, 1);

    // Redirect out of HALT to 2
    rom[5] = word(5);
    for (int i = 2; i <= 5; i++) sb_q.push_back(i);
    redirect_valid = 1'b1;
    redirect_pc = 32'd2;
    tick();
    redirect_valid = 1'b0;
    chk("redir_halted", {31'b0, halted}, 0);
    chk("redir_pc", pc, 2);
    chk("redir_flush", {31'b0, out_valid}, 0);

    // Redirect to 10 colliding with accept at pc=6
    wait_pc(6, 10);
    for (int i = 10; i <= 31; i++) sb_q.push_back(i);
    redirect_valid = 1'b1;
    redirect_pc = 32'd10;
    tick();
    redirect_valid = 1'b0;
    chk("collide_valid", {31'b0, out_valid}, 0);
    chk("collide_pc", pc, 10);
    chk("collide_fetch_cnt", {16'b0, fetch_cnt}, 8);
    tick();
    chk("collide_next_pc", out_pc, 10);

    // Run to 31, wrap to 0, null word halts
    k = 0;
    while (!halted && k < 40) begin
      tick();
      k++;
    end
    chk("wrap_halted", {31'b0, halted}, 1);
    chk("wrap_pc", pc, 0);
    chk("wrap_fetch_cnt", {16'b0, fetch_cnt}, 30);
    chk("wrap_drained", {31'b0, out_valid}, 0);

    // Illegal target faults; later redirects ignored
    redirect_valid = 1'b1;
    redirect_pc = 32'd32;
    tick();
    redirect_valid = 1'b0;
    chk("fault_set", {31'b0, fault}, 1);
    chk("fault_en_fetch", {31'b0, en_fetch}, 0);
    chk("fault_pc", pc, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'd3;
    tick();
    redirect_valid = 1'b0;
    chk("fault_ignore_pc", pc, 0);
    chk("fault_sticky", {31'b0, fault}, 1);
    rst = 1'b1;
    tick();
    chk("fault_clr", {31'b0, fault}, 0);
    chk("fault_rst_pc", pc, 1);
    chk("fault_rst_halted", {31'b0, halted}, 0);
    chk("fault_rst_cnt", {16'b0, fetch_cnt}, 0);

    // Redirect during IDLE is ignored
    sb_q.push_back(1);
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    tick();
    redirect_valid = 1'b0;
    chk("idle_redir_pc", pc, 1);

    // Reset overrides a simultaneous redirect and capture
    wait_pc(3, 10);
    chk("pre_rst_out_pc", out_pc, 2);
    chk("pre_rst_cnt", {16'b0, fetch_cnt}, 2);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd9;
    tick();
    redirect_valid = 1'b0;
    chk("mid_rst_pc", pc, 1);
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_cnt", {16'b0, fetch_cnt}, 0);
    chk("mid_rst_out_pc", out_pc, 0);
    tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
